// File: rtl/tuser_tdest_remap_if.sv
// AXI-Stream bundle for tuser_tdest_remap.
// Widths of 0 collapse to a 1-bit field.
interface tuser_tdest_remap_if #(
  parameter int BUS_W  = 64,
  parameter int ID_W   = 4,
  parameter int DEST_W = 4,
  parameter int USER_W = 8
);
  localparam int ID_P   = (ID_W   > 0) ? ID_W   : 1;
  localparam int DEST_P = (DEST_W > 0) ? DEST_W : 1;
  localparam int USER_P = (USER_W > 0) ? USER_W : 1;
  localparam int KEEP_W = BUS_W / 8;

  logic [BUS_W-1:0]  tdata;
  logic [ID_P-1:0]   tid;
  logic [DEST_P-1:0] tdest;
  logic [USER_P-1:0] tuser;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata, tid, tdest, tuser,
    output tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tid, tdest, tuser,
    input  tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/tuser_tdest_remap.sv
// Moves a tuser field onto tdest behind a two-entry skid buffer.
// Optional macro TUSER_DEST_LATCH_EN holds the first beat's dest per packet.
module tuser_tdest_remap #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_ID_WIDTH   = 4,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int AXIS_USER_WIDTH = 8,
  parameter int DEST_LSB        = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  tuser_tdest_remap_if.slave  axis_in,
  tuser_tdest_remap_if.master axis_out,
  output logic [31:0] pkt_count
);
  localparam int ID_P =
    (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1;
  localparam int DEST_P =
    (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1;
  localparam int USER_P =
    (AXIS_USER_WIDTH > 0) ? AXIS_USER_WIDTH : 1;
  localparam int KEEP_W = AXIS_BUS_WIDTH / 8;

  if (DEST_LSB + DEST_P > USER_P) begin : g_bad_lsb
    $error("dest field exceeds tuser width");
  end
  if (AXIS_BUS_WIDTH % 8 != 0) begin : g_bad_bus
    $error("bus width must be a multiple of 8");
  end

  typedef struct packed {
    logic [AXIS_BUS_WIDTH-1:0] data;
    logic [ID_P-1:0]           id;
    logic [DEST_P-1:0]         dest;
    logic [KEEP_W-1:0]         keep;
    logic                      last;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic              in_rdy_q;
  logic              out_vld_q;
  logic [31:0]       pkt_cnt_q;
  beat_t             out_q;
  beat_t             skid_q;
  beat_t             in_beat;
  logic [DEST_P-1:0] dest_field;
  logic [DEST_P-1:0] dest_sel;
  logic              in_acc;
  logic              out_acc;
  logic              ld_out_in;
  logic              ld_out_skid;
  logic              ld_skid;

  assign in_acc  = axis_in.tvalid & in_rdy_q;
  assign out_acc = out_vld_q & axis_out.tready;

  assign dest_field = axis_in.tuser[DEST_LSB +: DEST_P];

`ifdef TUSER_DEST_LATCH_EN
  logic              in_pkt_q;
  logic [DEST_P-1:0] dest_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      in_pkt_q <= 1'b0;
    end else if (in_acc) begin
      in_pkt_q <= ~axis_in.tlast;
    end
  end

  always_ff @(posedge aclk) begin
    if (in_acc && !in_pkt_q) begin
      dest_q <= dest_field;
    end
  end

  assign dest_sel = in_pkt_q ? dest_q : dest_field;
`else
  assign dest_sel = dest_field;
`endif

  always_comb begin
    in_beat      = '0;
    in_beat.data = axis_in.tdata;
    in_beat.id   = axis_in.tid;
    in_beat.dest = dest_sel;
    in_beat.keep = axis_in.tkeep;
    in_beat.last = axis_in.tlast;
  end

  // FULL never sees an input accept since tready is low there
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_EMPTY;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          in_rdy_q <= 1'b1;
          if (in_acc) begin
            state_q   <= ST_ONE;
            out_vld_q <= 1'b1;
          end else begin
            out_vld_q <= 1'b0;
          end
        end
        ST_ONE: begin
          if (in_acc && !out_acc) begin
            state_q   <= ST_FULL;
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b1;
          end else if (!in_acc && out_acc) begin
            state_q   <= ST_EMPTY;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
          end else begin
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b1;
          end
        end
        ST_FULL: begin
          out_vld_q <= 1'b1;
          if (out_acc) begin
            state_q  <= ST_ONE;
            in_rdy_q <= 1'b1;
          end else begin
            in_rdy_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_EMPTY;
          in_rdy_q  <= 1'b0;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign ld_out_in = in_acc &
    ((state_q == ST_EMPTY) |
     ((state_q == ST_ONE) & out_acc));
  assign ld_out_skid = (state_q == ST_FULL) & out_acc;
  assign ld_skid = (state_q == ST_ONE) &
    in_acc & ~out_acc;

  always_ff @(posedge aclk) begin
    if (ld_out_in) begin
      out_q <= in_beat;
    end else if (ld_out_skid) begin
      out_q <= skid_q;
    end
    if (ld_skid) begin
      skid_q <= in_beat;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q <= '0;
    end else if (out_acc && out_q.last) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

  assign axis_in.tready  = in_rdy_q;
  assign axis_out.tvalid = out_vld_q;
  assign axis_out.tdata  = out_q.data;
  assign axis_out.tid    = out_q.id;
  assign axis_out.tdest  = out_q.dest;
  assign axis_out.tkeep  = out_q.keep;
  assign axis_out.tlast  = out_q.last;
  assign axis_out.tuser  = '0;
  assign pkt_count       = pkt_cnt_q;
endmodule

// File: tb/tb_tuser_tdest_remap.sv
// Randomized and directed checks of tuser_tdest_remap
// against a queue-based reference model.
module tb_tuser_tdest_remap;
  localparam int DLSB = 4;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] pkt_count;

  tuser_tdest_remap_if #(
    .BUS_W(64), .ID_W(4), .DEST_W(4), .USER_W(8)
  ) in_if ();
  tuser_tdest_remap_if #(
    .BUS_W(64), .ID_W(4), .DEST_W(4), .USER_W(8)
  ) out_if ();

  tuser_tdest_remap #(
    .AXIS_BUS_WIDTH(64),
    .AXIS_ID_WIDTH(4),
    .AXIS_DEST_WIDTH(4),
    .AXIS_USER_WIDTH(8),
    .DEST_LSB(DLSB)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .axis_in(in_if),
    .axis_out(out_if),
    .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  id;
    logic [3:0]  dest;
    logic [7:0]  keep;
    logic        last;
  } exp_t;

  exp_t        q[$];
  logic [3:0]  seen[$];
  bit          m_rdy;
  logic [31:0] m_cnt;
  bit          m_open;
  logic [3:0]  m_dest;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_rdy  = 1'b0;
    m_cnt  = '0;
    m_open = 1'b0;
    m_dest = '0;
  endfunction

  function automatic void push_beat(
    input logic [63:0] d, input logic [3:0] id,
    input logic [7:0] u, input logic [7:0] k,
    input bit l);
    exp_t e;
    logic [3:0] f;
    f = u[DLSB +: 4];
    e.d = d; e.id = id; e.keep = k; e.last = l;
`ifdef TUSER_DEST_LATCH_EN
    if (!m_open) m_dest = f;
    e.dest = m_dest;
    m_open = !l;
`else
    e.dest = f;
`endif
    q.push_back(e);
  endfunction

  task automatic check_outputs();
    check("out_vld", {63'd0, out_if.tvalid},
          {63'd0, q.size() > 0});
    check("in_rdy", {63'd0, in_if.tready},
          {63'd0, m_rdy});
    check("pkt_cnt", {32'd0, pkt_count},
          {32'd0, m_cnt});
    if (q.size() > 0 && out_if.tvalid) begin
      check("data", out_if.tdata, q[0].d);
      check("id", {60'd0, out_if.tid}, {60'd0, q[0].id});
      check("dest", {60'd0, out_if.tdest},
            {60'd0, q[0].dest});
      check("keep", {56'd0, out_if.tkeep},
            {56'd0, q[0].keep});
      check("last", {63'd0, out_if.tlast},
            {63'd0, q[0].last});
    end
  endtask

  task automatic cycle(
    input bit v, input logic [63:0] d,
    input logic [3:0] id, input logic [7:0] u,
    input logic [7:0] k, input bit l,
    input bit ordy);
    bit in_acc, out_acc;
    exp_t e;
    in_if.tvalid  = v;
    in_if.tdata   = d;
    in_if.tid     = id;
    in_if.tuser   = u;
    in_if.tkeep   = k;
    in_if.tlast   = l;
    in_if.tdest   = '0;
    out_if.tready = ordy;
    in_acc  = v && m_rdy && aresetn;
    out_acc = (q.size() > 0) && ordy && aresetn;
    if (out_acc) seen.push_back(out_if.tdest);
    @(negedge aclk);
    cyc++;
    if (!aresetn) begin
      model_reset();
    end else begin
      if (out_acc) begin
        e = q.pop_front();
        if (e.last) m_cnt = m_cnt + 32'd1;
      end
      if (in_acc) push_beat(d, id, u, k, l);
      m_rdy = q.size() < 2;
    end
    check_outputs();
  endtask

  task automatic idle(input int n, input bit ordy);
    repeat (n) cycle(0, 64'd0, 4'd0, 8'd0, 8'd0, 0, ordy);
  endtask

  task automatic send(
    input logic [63:0] d, input logic [3:0] id,
    input logic [7:0] u, input bit l, input bit ordy);
    bit done;
    done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      done = m_rdy && aresetn;
      cycle(1, d, id, u, 8'hFF, l, ordy);
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    model_reset();
    idle(2, 1);
    aresetn = 1'b1;
    idle(1, 1);
  endtask

  logic [63:0] rd;
  logic [3:0]  exp_d[4];
  int          c0;
  int          nacc;

  initial begin
    model_reset();
    in_if.tvalid  = 0;
    out_if.tready = 0;
    @(negedge aclk);
    check_outputs();
    do_reset();

    // single beat, dest from tuser[7:4]
    send(64'h1111_2222_3333_4444, 4'h1, 8'h3A, 1, 1);
    check("r28_dest", {60'd0, out_if.tdest}, 64'h3);
    idle(1, 1);
    check("r28_cnt", {32'd0, pkt_count}, 64'd1);

    // 8-beat burst at full rate
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom}, 4'(i), 8'($urandom),
           i == 7, 1);
    check("burst_cycles", 64'(cyc - c0), 64'd8);
    idle(2, 1);
    check("burst_cnt", {32'd0, pkt_count}, 64'd2);

    // stall: only two beats fit
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_rdy) nacc++;
      cycle(1, 64'hA0 + 64'(nacc), 4'(nacc), 8'h10,
            8'hFF, nacc == 2, 0);
    end
    check("stall_acc", 64'(nacc), 64'd2);
    check("stall_rdy", {63'd0, in_if.tready}, 64'd0);
    send(64'hA2, 4'd2, 8'h10, 1, 1);
    idle(3, 1);

    // dest per beat vs latched per packet
    seen.delete();
    send(64'h1, 4'd0, 8'h5C, 0, 1);
    send(64'h2, 4'd0, 8'h71, 0, 1);
    send(64'h3, 4'd0, 8'h7F, 0, 1);
    send(64'h4, 4'd0, 8'h20, 1, 1);
    idle(3, 1);
`ifdef TUSER_DEST_LATCH_EN
    exp_d = '{4'd5, 4'd5, 4'd5, 4'd5};
`else
    exp_d = '{4'd5, 4'd7, 4'd7, 4'd2};
`endif
    check("r31_n", 64'(seen.size()), 64'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check("r31_dest", {60'd0, seen[i]},
            {60'd0, exp_d[i]});

    // async reset while full, with a packet open
    send(64'hB0, 4'd3, 8'h90, 0, 0);
    send(64'hB1, 4'd3, 8'h90, 0, 0);
    #2 aresetn = 1'b0;
    #1;
    check("rst_vld", {63'd0, out_if.tvalid}, 64'd0);
    check("rst_rdy", {63'd0, in_if.tready}, 64'd0);
    check("rst_cnt", {32'd0, pkt_count}, 64'd0);
    model_reset();
    idle(1, 1);
    aresetn = 1'b1;
    idle(1, 1);
    send(64'hC0, 4'd4, 8'hC1, 0, 1);
    check("rst_first", {60'd0, out_if.tdest}, 64'hC);
    send(64'hC1, 4'd4, 8'h31, 1, 1);
    idle(3, 1);

    // counter wrap
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    send(64'hD0, 4'd5, 8'h44, 1, 1);
    idle(2, 1);
    check("wrap", {32'd0, pkt_count}, 64'd0);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      rd = {$urandom, $urandom};
      cycle(($urandom % 4) != 0, rd, 4'($urandom),
            8'($urandom), 8'($urandom),
            ($urandom % 4) == 0, ($urandom % 3) != 0);
    end
    idle(4, 1);
    check("drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
